lfsr_checker: RTL and testbench

Receive-side companion to the 8-bit Fibonacci LFSR pattern generator (x^8+x^6+x^5+x^4+1, shift-left, feedback = b7^b5^b4^b3 into bit 0, seed 0x01, period 255). It accepts one 8-bit LFSR state per valid cycle, self-synchronises to the sequence, and flags and counts deviations. It sits at the sink end of a pattern link as a built-in self-test monitor.

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_checker.sv | 140 ++++++++++++++
 tb/tb_lfsr_checker.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Fibonacci LFSR pattern generator and checker
// (x^8+x^6+x^5+x^4+1, shift-left, feedback into bit 0).
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], ^(x & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR monitor: self-synchronises to the incoming pattern, then
// flywheels its prediction and flags, counts and reacts to deviations.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap_pulse,
  output logic [1:0]       state
);

  localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

  lfsr_state_e      state_r, state_nxt_s;
  logic [7:0]       pred_r, pred_nxt_s;
  logic [3:0]       match_cnt_r, match_cnt_nxt_s;
  logic [3:0]       miss_cnt_r, miss_cnt_nxt_s;
  logic             locked_r, err_pulse_r, wrap_pulse_r;
  logic             err_pulse_nxt_s, wrap_pulse_nxt_s, err_inc_s;
  logic [ERR_W-1:0] err_count_r, err_count_nxt_s;

  // Next-state, prediction and pulse decode
  always_comb begin
    state_nxt_s      = state_r;
    pred_nxt_s       = pred_r;
    match_cnt_nxt_s  = match_cnt_r;
    miss_cnt_nxt_s   = miss_cnt_r;
    err_pulse_nxt_s  = 1'b0;
    wrap_pulse_nxt_s = 1'b0;
    err_inc_s        = 1'b0;
    case (state_r)
      HUNT: begin
        if (in_valid && (in_data != 8'h00)) begin
          pred_nxt_s      = lfsr_next(in_data);
          match_cnt_nxt_s = 4'd0;
          state_nxt_s     = VERIFY;
        end else begin
          state_nxt_s = HUNT;
        end
      end
      VERIFY: begin
        if (!in_valid) begin
          state_nxt_s = VERIFY;
        end else if (in_data == pred_r) begin
          match_cnt_nxt_s = match_cnt_r + 4'd1;
          pred_nxt_s      = lfsr_next(in_data);
          if ((match_cnt_r + 4'd1) == LOCK_C) begin
            state_nxt_s    = LOCKED;
            miss_cnt_nxt_s = 4'd0;
          end else begin
            state_nxt_s = VERIFY;
          end
        end else if (in_data != 8'h00) begin
          // Wrong but plausible word: resynchronise to it
          pred_nxt_s      = lfsr_next(in_data);
          match_cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s = HUNT;
        end
      end
      LOCKED: begin
        if (!in_valid) begin
          state_nxt_s = LOCKED;
        end else begin
          // Flywheel: the received word never reseeds the prediction here
          pred_nxt_s = lfsr_next(pred_r);
          if (in_data == pred_r) begin
            miss_cnt_nxt_s   = 4'd0;
            wrap_pulse_nxt_s = (in_data == LFSR_SEED);
          end else begin
            err_pulse_nxt_s = 1'b1;
            err_inc_s       = 1'b1;
            if ((miss_cnt_r + 4'd1) == LOSS_C) begin
              state_nxt_s    = HUNT;
              miss_cnt_nxt_s = 4'd0;
            end else begin
              miss_cnt_nxt_s = miss_cnt_r + 4'd1;
            end
          end
        end
      end
      default: begin
        state_nxt_s = HUNT;
      end
    endcase
  end

  // Saturating error counter; clear wins over a same-cycle increment
  always_comb begin
    err_count_nxt_s = err_count_r;
    if (clr_cnt) begin
      err_count_nxt_s = '0;
    end else if (err_inc_s && (err_count_r != {ERR_W{1'b1}})) begin
      err_count_nxt_s = err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_count_nxt_s = err_count_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= HUNT;
      pred_r       <= 8'h00;
      match_cnt_r  <= 4'd0;
      miss_cnt_r   <= 4'd0;
      locked_r     <= 1'b0;
      err_pulse_r  <= 1'b0;
      wrap_pulse_r <= 1'b0;
      err_count_r  <= '0;
    end else begin
      state_r      <= state_nxt_s;
      pred_r       <= pred_nxt_s;
      match_cnt_r  <= match_cnt_nxt_s;
      miss_cnt_r   <= miss_cnt_nxt_s;
      locked_r     <= (state_nxt_s == LOCKED);
      err_pulse_r  <= err_pulse_nxt_s;
      wrap_pulse_r <= wrap_pulse_nxt_s;
      err_count_r  <= err_count_nxt_s;
    end
  end

  assign locked     = locked_r;
  assign err_pulse  = err_pulse_r;
  assign err_count  = err_count_r;
  assign wrap_pulse = wrap_pulse_r;
  assign state      = state_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, single error, loss, zero/gap handling,
// wrap detection, counter saturation/clear and mid-lock reset.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst, in_valid, clr_cnt;
  logic [7:0]  in_data;
  logic        locked, err_pulse, wrap_pulse;
  logic [15:0] err_count;
  logic [1:0]  state;
  logic        s_locked, s_err_pulse, s_wrap_pulse;
  logic [3:0]  s_err_count;
  logic [1:0]  s_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .wrap_pulse(wrap_pulse), .state(state)
  );

  lfsr_checker #(.ERR_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
    .wrap_pulse(s_wrap_pulse), .state(s_state)
  );

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clr_cnt  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] mp;
    logic [7:0] w;
    int wraps;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_wrap_pulse", 32'(wrap_pulse), 32'd0);
    rst = 1'b0;

    // Lock on 01,02,04,08,11
    step(1'b1, 8'h01, 1'b0); chk("verify_after_01", 32'(state), 32'd1);
    step(1'b1, 8'h02, 1'b0); chk("not_locked_02", 32'(locked), 32'd0);
    step(1'b1, 8'h04, 1'b0); chk("not_locked_04", 32'(locked), 32'd0);
    step(1'b1, 8'h08, 1'b0); chk("not_locked_08", 32'(locked), 32'd0);
    step(1'b1, 8'h11, 1'b0); chk("locked_after_11", 32'(locked), 32'd1);
    chk("state_locked", 32'(state), 32'd2);
    chk("err_after_lock", 32'(err_count), 32'd0);

    // Single error: 23, FF (expected 47), 8E, 1C
    step(1'b1, 8'h23, 1'b0); chk("no_err_23", 32'(err_pulse), 32'd0);
    step(1'b1, 8'hFF, 1'b0); chk("err_pulse_FF", 32'(err_pulse), 32'd1);
    chk("err_count_1", 32'(err_count), 32'd1);
    chk("still_locked_FF", 32'(locked), 32'd1);
    step(1'b1, 8'h8E, 1'b0); chk("flywheel_8E", 32'(err_pulse), 32'd0);
    step(1'b1, 8'h1C, 1'b0); chk("flywheel_1C", 32'(err_pulse), 32'd0);
    chk("err_count_still_1", 32'(err_count), 32'd1);

    // Loss: three wrong words against expected 38,71,E2
    step(1'b1, 8'h55, 1'b0); chk("loss_cnt_2", 32'(err_count), 32'd2);
    chk("loss_locked_1", 32'(locked), 32'd1);
    step(1'b1, 8'h55, 1'b0); chk("loss_cnt_3", 32'(err_count), 32'd3);
    chk("loss_locked_2", 32'(locked), 32'd1);
    step(1'b1, 8'h55, 1'b0); chk("loss_cnt_4", 32'(err_count), 32'd4);
    chk("loss_pulse_3", 32'(err_pulse), 32'd1);
    chk("loss_unlocked", 32'(locked), 32'd0);
    chk("loss_hunt", 32'(state), 32'd0);

    // Zero ignored in HUNT, then sequence with gaps
    step(1'b1, 8'h00, 1'b0); chk("zero_ignored", 32'(state), 32'd0);
    mp = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, mp, 1'b0);
      chk("gap_seq_locked", 32'(locked), (i == 4) ? 32'd1 : 32'd0);
      step(1'b0, 8'hAA, 1'b0);
      chk("gap_hold_state", 32'(state), (i == 4) ? 32'd2 : 32'd1);
      mp = nxt(mp);
    end
    chk("gap_no_err", 32'(err_count), 32'd4);

    // Twenty isolated errors: ERR_W=4 instance saturates
    for (int i = 0; i < 20; i++) begin
      step(1'b1, mp ^ 8'h80, 1'b0);
      chk("sat_err_pulse", 32'(err_pulse), 32'd1);
      mp = nxt(mp);
      step(1'b1, mp, 1'b0);
      mp = nxt(mp);
    end
    chk("sat_locked", 32'(locked), 32'd1);
    chk("sat_main_count", 32'(err_count), 32'd24);
    chk("sat_small_count", 32'(s_err_count), 32'd15);

    // Clear coincident with an error
    step(1'b1, mp ^ 8'h80, 1'b1);
    mp = nxt(mp);
    chk("clr_pulse", 32'(err_pulse), 32'd1);
    chk("clr_main", 32'(err_count), 32'd0);
    chk("clr_small", 32'(s_err_count), 32'd0);

    // Run the sequence past a full period; wrap only on matching 01
    wraps = 0;
    for (int i = 0; i < 300; i++) begin
      w = mp;
      step(1'b1, w, 1'b0);
      chk("wrap_pulse", 32'(wrap_pulse), (w == 8'h01) ? 32'd1 : 32'd0);
      if (wrap_pulse) wraps++;
      mp = nxt(mp);
    end
    chk("wrap_seen", 32'(wraps > 0), 32'd1);
    chk("wrap_no_err", 32'(err_count), 32'd0);

    // Reset mid-lock
    step(1'b1, mp ^ 8'h80, 1'b0);
    chk("pre_rst_count", 32'(err_count), 32'd1);
    rst = 1'b1;
    step(1'b1, 8'h77, 1'b0);
    chk("rst_mid_locked", 32'(locked), 32'd0);
    chk("rst_mid_count", 32'(err_count), 32'd0);
    chk("rst_mid_state", 32'(state), 32'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
